// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - multi-channel button debouncer with press/release/long/repeat events
//
// Each channel: optional input inversion, 2-flop synchroniser, tick-based
// debounce, then a small IDLE/HOLD/LONG FSM producing long-press and
// auto-repeat pulses. All timing is counted in i_tick strobes.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   i_tick    one-clk timing strobe (nominally 1 ms)
//   i_btn     raw asynchronous button inputs, one bit per channel
//   o_level   debounced stable level, 1 = pressed
//   o_press   one-clk pulse, cycle after o_level rises
//   o_release one-clk pulse, cycle after o_level falls
//   o_long    one-clk pulse when a hold reaches LONG_TICKS
//   o_repeat  one-clk pulse every REPEAT_TICKS while in long-press
module btn_event_ctrl #(
  parameter int N_BTN          = 4,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 200,
  parameter int ACTIVE_LOW_IN  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int DW       = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int HW       = $clog2(LONG_TICKS) + 1;
  localparam int RW       = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS) + 1 : 1;
  localparam int REP_LAST = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_LONG} state_t;

  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] level_prev;

  assign btn_in = (ACTIVE_LOW_IN != 0) ? ~i_btn : i_btn;

  // Synchroniser and edge pulses; pulses compare the level against its
  // one-cycle-old copy, so they land in the cycle after o_level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      level_prev <= '0;
      o_press    <= '0;
      o_release  <= '0;
    end else begin
      sync1      <= btn_in;
      sync2      <= sync1;
      level_prev <= o_level;
      o_press    <= o_level & ~level_prev;
      o_release  <= ~o_level & level_prev;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic          level_q;
    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;
    logic          long_q;
    logic          long_nxt;
    logic          rep_q;
    logic          rep_pulse_nxt;

    assign o_level[g]  = level_q;
    assign o_long[g]   = long_q;
    assign o_repeat[g] = rep_q;

    // Debounce: only a full run of mismatching ticks moves the level;
    // any agreeing tick restarts the qualification.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (i_tick) begin
        if (sync2[g] != level_q) begin
          if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
            level_q <= sync2[g];
            db_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        hold_cnt <= hold_nxt;
        rep_cnt  <= rep_nxt;
        long_q   <= long_nxt;
        rep_q    <= rep_pulse_nxt;
      end
    end

    // Release is tested before any tick handling so a release cycle can
    // never also emit a long or repeat pulse.
    always_comb begin
      state_nxt     = state;
      hold_nxt      = hold_cnt;
      rep_nxt       = rep_cnt;
      long_nxt      = 1'b0;
      rep_pulse_nxt = 1'b0;
      case (state)
        ST_IDLE: begin
          if (level_q) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
          end
        end
        ST_HOLD: begin
          if (!level_q) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
          end else if (i_tick) begin
            if (hold_cnt == HW'(LONG_TICKS - 1)) begin
              long_nxt  = 1'b1;
              state_nxt = ST_LONG;
              hold_nxt  = '0;
              rep_nxt   = '0;
            end else begin
              hold_nxt = hold_cnt + 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (!level_q) begin
            state_nxt = ST_IDLE;
            rep_nxt   = '0;
          end else if ((REPEAT_TICKS > 0) && i_tick) begin
            if (rep_cnt == RW'(REP_LAST)) begin
              rep_pulse_nxt = 1'b1;
              rep_nxt       = '0;
            end else begin
              rep_nxt = rep_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = '0;
          rep_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - scoreboard bench for btn_event_ctrl
module tb_btn_event_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_tick;
  logic [3:0] btn0;
  logic [3:0] btn1;
  logic [3:0] level0, press0, release0, long0, repeat0;
  logic [3:0] level1, press1, release1, long1, repeat1;

  int n_assert;
  int n_fail;
  int tick_idx;
  int press_tick [2];

  typedef struct {
    int       dut;
    int       kind;
    logic [3:0] mask;
    int       dt;
  } ev_t;

  ev_t sb [$];

  logic [3:0] obs [2][4];

  btn_event_ctrl #(
    .N_BTN(4), .DEBOUNCE_TICKS(20), .LONG_TICKS(1000),
    .REPEAT_TICKS(200), .ACTIVE_LOW_IN(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_btn(btn0),
    .o_level(level0), .o_press(press0), .o_release(release0),
    .o_long(long0), .o_repeat(repeat0)
  );

  btn_event_ctrl #(
    .N_BTN(4), .DEBOUNCE_TICKS(20), .LONG_TICKS(1000),
    .REPEAT_TICKS(0), .ACTIVE_LOW_IN(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_btn(btn1),
    .o_level(level1), .o_press(press1), .o_release(release1),
    .o_long(long1), .o_repeat(repeat1)
  );

  assign obs[0][0] = press0;
  assign obs[0][1] = release0;
  assign obs[0][2] = long0;
  assign obs[0][3] = repeat0;
  assign obs[1][0] = press1;
  assign obs[1][1] = release1;
  assign obs[1][2] = long1;
  assign obs[1][3] = repeat1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tick_idx=%0d required completion", tick_idx);
    $fatal(1);
  end

  // Scoreboard consumer: every pulse must match the oldest expected event;
  // dt (when >= 0) is the required tick distance from that DUT's last press.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          if (obs[d][k] != 4'b0000) begin
            n_assert++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_pulse: dut%0d kind%0d mask=%b, required none", d, k, obs[d][k]);
            end else begin
              e = sb.pop_front();
              if (e.dut != d || e.kind != k || e.mask !== obs[d][k]) begin
                n_fail++;
                $display("FAIL event: got dut%0d kind%0d mask=%b, required dut%0d kind%0d mask=%b",
                         d, k, obs[d][k], e.dut, e.kind, e.mask);
              end else if (e.dt >= 0) begin
                n_assert++;
                if (tick_idx - press_tick[d] != e.dt) begin
                  n_fail++;
                  $display("FAIL event_timing: dut%0d kind%0d at %0d ticks after press, required %0d",
                           d, k, tick_idx - press_tick[d], e.dt);
                end
              end
            end
            if (k == 0) press_tick[d] = tick_idx;
          end
        end
      end
    end
  end

  task automatic push_ev(input int d, input int k, input logic [3:0] m, input int dt);
    ev_t e;
    e.dut = d; e.kind = k; e.mask = m; e.dt = dt;
    sb.push_back(e);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) i_tick = 1'b1;
      tick_idx++;
      @(negedge clk) i_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic set_btn(input int d, input logic [3:0] v);
    @(negedge clk);
    if (d == 0) btn0 = v; else btn1 = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_tick = 1'b0; btn0 = '0; btn1 = '0;
    repeat (4) @(negedge clk);
    n_assert++;
    if ({level0, press0, release0, long0, repeat0, level1, press1, release1, long1, repeat1} !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {level0, press0, release0, long0, repeat0, level1, press1, release1, long1, repeat1});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({level0, press0, release0, long0, repeat0} !== 20'd0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got %h, required 0", {level0, press0, release0, long0, repeat0});
    end
  endtask

  task automatic test_debounce_threshold;
    set_btn(0, 4'b0001);
    do_ticks(19);
    n_assert++;
    if (level0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL debounce_19: level=%b, required 0000", level0);
    end
    set_btn(0, 4'b0000);
    do_ticks(2);
    push_ev(0, 0, 4'b0001, -1);
    set_btn(0, 4'b0001);
    do_ticks(20);
    n_assert++;
    if (level0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL debounce_20_level: level=%b, required 0001", level0);
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL debounce_20_press: %0d events pending, required 0", sb.size());
    end
    push_ev(0, 1, 4'b0001, -1);
    set_btn(0, 4'b0000);
    do_ticks(21);
    n_assert++;
    if (sb.size() != 0 || level0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL debounce_release: pending=%0d level=%b, required 0 and 0000", sb.size(), level0);
    end
  endtask

  task automatic test_chatter;
    logic [3:0] v;
    v = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      v[2] = ~v[2];
      set_btn(0, v);
      do_ticks(5);
    end
    n_assert++;
    if (level0 !== 4'b0000 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL chatter: level=%b pending=%0d, required 0000 and 0", level0, sb.size());
    end
  endtask

  task automatic test_long_repeat;
    push_ev(0, 0, 4'b0010, -1);
    push_ev(0, 2, 4'b0010, 1000);
    push_ev(0, 3, 4'b0010, 1200);
    push_ev(0, 3, 4'b0010, 1400);
    push_ev(0, 3, 4'b0010, 1600);
    set_btn(0, 4'b0010);
    do_ticks(20);
    do_ticks(1700);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL long_repeat: %0d events pending, required 0", sb.size());
    end
    push_ev(0, 1, 4'b0010, -1);
    set_btn(0, 4'b0000);
    do_ticks(25);
    n_assert++;
    if (sb.size() != 0 || level0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL long_release: pending=%0d level=%b, required 0 and 0000", sb.size(), level0);
    end
  endtask

  task automatic test_simultaneous;
    push_ev(0, 0, 4'b1001, -1);
    set_btn(0, 4'b1001);
    do_ticks(21);
    n_assert++;
    if (sb.size() != 0 || level0 !== 4'b1001) begin
      n_fail++;
      $display("FAIL simul_press: pending=%0d level=%b, required 0 and 1001", sb.size(), level0);
    end
    push_ev(0, 1, 4'b1001, -1);
    set_btn(0, 4'b0000);
    do_ticks(21);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL simul_release: %0d events pending, required 0", sb.size());
    end
  endtask

  task automatic test_no_repeat;
    push_ev(1, 0, 4'b0001, -1);
    push_ev(1, 2, 4'b0001, 1000);
    set_btn(1, 4'b0001);
    do_ticks(20);
    do_ticks(3000);
    n_assert++;
    if (sb.size() != 0 || level1 !== 4'b0001) begin
      n_fail++;
      $display("FAIL no_repeat_hold: pending=%0d level=%b, required 0 and 0001", sb.size(), level1);
    end
    push_ev(1, 1, 4'b0001, -1);
    set_btn(1, 4'b0000);
    do_ticks(21);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL no_repeat_release: %0d events pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_in_long;
    push_ev(0, 0, 4'b0010, -1);
    push_ev(0, 2, 4'b0010, 1000);
    set_btn(0, 4'b0010);
    do_ticks(20);
    do_ticks(1050);
    n_assert++;
    if (sb.size() != 0 || level0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL pre_reset_long: pending=%0d level=%b, required 0 and 0010", sb.size(), level0);
    end
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_assert++;
    if ({level0, press0, release0, long0, repeat0} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_immediate: got %h, required 0", {level0, press0, release0, long0, repeat0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_ev(0, 0, 4'b0010, -1);
    repeat (3) @(negedge clk);
    do_ticks(19);
    n_assert++;
    if (level0 !== 4'b0000 || sb.size() != 1) begin
      n_fail++;
      $display("FAIL requalify_19: level=%b pending=%0d, required 0000 and 1", level0, sb.size());
    end
    do_ticks(1);
    n_assert++;
    if (level0 !== 4'b0010 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL requalify_20: level=%b pending=%0d, required 0010 and 0", level0, sb.size());
    end
    push_ev(0, 1, 4'b0010, -1);
    set_btn(0, 4'b0000);
    do_ticks(21);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL requalify_release: %0d events pending, required 0", sb.size());
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    tick_idx = 0;
    press_tick[0] = 0;
    press_tick[1] = 0;
    test_reset;
    test_debounce_threshold;
    test_chatter;
    test_long_repeat;
    test_simultaneous;
    test_no_repeat;
    test_reset_in_long;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 Parameter N_BTN, default 4: number of independent button channels, range 1..16.
REQ-002 Parameter DEBOUNCE_TICKS, default 20: consecutive mismatching ticks before the stable level changes, range 1..255.
REQ-003 Parameter LONG_TICKS, default 1000: ticks of continuous stable press before a long-press event, range 1..65535.
REQ-004 Parameter REPEAT_TICKS, default 200: tick period of auto-repeat after long press; 0 disables repeat.
REQ-005 Parameter ACTIVE_LOW_IN, default 0: 1 inverts all raw inputs before synchronisation.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 i_tick  input  1  one-clk strobe, nominally 1 ms; all timing counts in ticks.
REQ-009 i_btn  input  N_BTN  raw asynchronous button inputs.
REQ-010 o_level  output  N_BTN  debounced stable level, 1 = pressed.
REQ-011 o_press  output  N_BTN  one-clk pulse on stable 0->1.
REQ-012 o_release  output  N_BTN  one-clk pulse on stable 1->0.
REQ-013 o_long  output  N_BTN  one-clk pulse when hold reaches LONG_TICKS.
REQ-014 o_repeat  output  N_BTN  one-clk pulse at each repeat interval after o_long.

Function
REQ-015 Each i_btn bit, after optional inversion, SHALL pass a 2-flop synchroniser; debounce logic sees only the synchronised value.
REQ-016 Per channel, on a tick with synchronised input != o_level, the debounce counter SHALL increment; on the tick where it already equals DEBOUNCE_TICKS-1, o_level SHALL take the input value and the counter SHALL clear.
REQ-017 On a tick with synchronised input == o_level, the debounce counter SHALL clear; between ticks the counter SHALL hold.
REQ-018 o_press/o_release SHALL assert for exactly one clk, in the cycle after o_level changes.
REQ-019 Per-channel FSM states: IDLE (o_level=0), HOLD (pressed, before long), LONG (long reached); IDLE->HOLD on o_level rise, HOLD->LONG at long event, any->IDLE on o_level fall.
REQ-020 Hold counter SHALL clear on entry to HOLD and increment on each tick while in HOLD; on the tick it reaches LONG_TICKS, o_long SHALL pulse for one clk and FSM SHALL enter LONG.
REQ-021 In LONG with REPEAT_TICKS>0, a repeat counter SHALL clear on entry and count ticks; at REPEAT_TICKS, o_repeat SHALL pulse for one clk and the counter SHALL restart from 0; counters never wrap.
REQ-022 With REPEAT_TICKS=0, o_repeat SHALL stay 0 and LONG SHALL persist until release.
REQ-023 Release in HOLD or LONG SHALL return the FSM to IDLE, clear hold/repeat counters, and suppress any long/repeat pulse on that cycle; o_release still pulses.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-025 Counter widths SHALL be sized by $clog2 of their parameter plus 1; no overflow for any legal parameter value.

Reset
REQ-026 While rst_n=0: synchronisers, o_level, all counters and the FSMs SHALL be 0/IDLE, and o_press, o_release, o_long, o_repeat SHALL be 0.
REQ-027 Reset asserted mid-press SHALL clear state immediately without emitting o_release; after deassertion, a button still held SHALL re-qualify via full debounce and then produce o_press.

Verification
REQ-028 N_BTN=4, DEBOUNCE_TICKS=20: hold i_btn[0]=1 for 19 ticks then 0 -> no o_press; hold 20 ticks -> o_level[0]=1 and exactly one o_press[0] pulse.
REQ-029 Chatter: toggle i_btn[2] every 5 ticks for 200 ticks -> o_level[2] stays 0, no pulses on any output.
REQ-030 LONG_TICKS=1000, REPEAT_TICKS=200: hold i_btn[1] for 1700 ticks after debounce -> one o_long[1], then o_repeat[1] at +200, +400, +600 ticks (3 pulses), then release -> one o_release[1].
REQ-031 REPEAT_TICKS=0: hold 3000 ticks -> one o_long, zero o_repeat.
REQ-032 Press channels 0 and 3 on the same clk -> o_press=4'b1001 in a single cycle.
REQ-033 rst_n pulsed low during LONG on channel 1 -> all outputs 0 immediately, no o_release; button still held -> o_press[1] after 20 ticks plus sync latency.
